seg7_to_bin: RTL
================

SEG7_TO_BIN -- requirements
Module: seg7_to_bin

Interface
REQ-001 Parameter NDIG, default 8, number of scanned digits (2..8).
REQ-002 Parameter TMO, default 1023, max cycles from first sample to frame completion.
REQ-003 clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst_i  in  1  reset, synchronous, active-high.
REQ-005 seg_valid_i  in  1  segment sample valid this cycle.
REQ-006 seg_i  in  7  active-low segment pattern; bit0=a … bit6=g.
REQ-007 dig_i  in  3  digit index of the sample (0 = least-significant nibble).
REQ-008 frame_ready_i  in  1  consumer accepts frame.
REQ-009 frame_valid_o  out  1  complete frame held.
REQ-010 frame_data_o  out  4*NDIG  decoded nibbles; digit k at bits [4k+3:4k].
REQ-011 err_mask_o  out  NDIG  bit k set = digit k pattern not in decode table.
REQ-012 timeout_o  out  1  one-cycle pulse when a partial frame is discarded.
REQ-013 drop_cnt_o  out  8  saturating count of samples dropped while holding.

Function
REQ-014 Decode table (seg_i hex -> nibble): 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9, 08->A, 03->B, 46->C, 21->D, 06->E, 0E->F.
REQ-015 Any other pattern (including 3F dash, 7F blank) decodes to nibble 0 and sets that digit's error bit.
REQ-016 Two states: COLLECT (accepting samples), HOLD (frame presented).
REQ-017 COLLECT: accepted sample (seg_valid_i=1, dig_i<NDIG) writes the nibble and error bit to slot dig_i and sets seen[dig_i].
REQ-018 Samples with dig_i>=NDIG are ignored in all states, not counted.
REQ-019 Repeated sample for an already-seen digit overwrites slot and error bit (last value wins).
REQ-020 When seen becomes all-ones (including the current cycle's sample), the state moves to HOLD next edge; frame_valid_o is high from cycle N+1 for a completing sample at cycle N.
REQ-021 frame_data_o and err_mask_o are stable throughout HOLD and change only in COLLECT.
REQ-022 HOLD: each valid in-range sample is dropped and increments drop_cnt_o, saturating at 255.
REQ-023 Handshake: frame transfers on a cycle with frame_valid_o=1 and frame_ready_i=1; next cycle the state is COLLECT, seen is cleared, and frame_valid_o is 0.
REQ-024 A sample on the transfer cycle is dropped (state still HOLD) and counted.
REQ-025 frame_valid_o, once asserted, stays high until the transfer; frame_ready_i in COLLECT has no effect.
REQ-026 Timeout counter starts at the first accepted sample of a frame (seen was zero) and increments each COLLECT cycle.
REQ-027 If the counter reaches TMO with seen not all-ones, seen is cleared, the counter is reset, and timeout_o pulses for one cycle; slot contents are retained but are stale.
REQ-028 A sample that completes the frame on the same cycle the counter reaches TMO wins: the block enters HOLD and timeout_o stays 0.
REQ-029 The timeout counter is idle (zero) in HOLD and while seen is zero.
REQ-030 drop_cnt_o is cleared only by reset.

Reset
REQ-031 rst_i=1 at an edge forces next cycle: state COLLECT, seen=0, slots=0, frame_data_o=0, err_mask_o=0, frame_valid_o=0, timeout_o=0, drop_cnt_o=0, timeout counter=0.
REQ-032 Reset overrides any in-progress frame or pending handshake; samples during reset are discarded.

Verification
REQ-033 NDIG=8: samples digits 0..7 = 79,24,30,19,12,02,78,00 -> frame_valid_o at cycle after digit 7; frame_data_o=0x87654321, err_mask_o=0.
REQ-034 Digit 3 = 3F, others valid; digit 3 then resent as 46 before completion -> err_mask_o=0, nibble 3 = C.
REQ-035 Hold frame with frame_ready_i=0 for 300 cycles with samples every cycle -> data stable, drop_cnt_o=255; ready=1 -> valid drops next cycle.
REQ-036 TMO=15: 3 digits sent, then idle -> timeout_o pulses 15 cycles after first sample; a fresh full frame then completes normally.
REQ-037 Reset asserted mid-frame and during HOLD -> all outputs zero next cycle; a full frame after reset decodes correctly.
REQ-038 dig_i=7 with NDIG=4 -> ignored; frame completes on digits 0..3 only.

Source files
------------

// File: rtl/seg7_to_bin.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_to_bin
//  Description : Collects scanned active-low 7-segment digit samples into a
//                frame of decoded nibbles. A complete frame is held until it
//                is accepted. A partial frame is discarded after a timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_to_bin #(
  parameter int NDIG = 8,
  parameter int TMO  = 1023
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              seg_valid_i,
  input  logic [6:0]        seg_i,
  input  logic [2:0]        dig_i,
  input  logic              frame_ready_i,
  output logic              frame_valid_o,
  output logic [4*NDIG-1:0] frame_data_o,
  output logic [NDIG-1:0]   err_mask_o,
  output logic              timeout_o,
  output logic [7:0]        drop_cnt_o
);

  localparam int         TW     = $clog2(TMO + 1);
  localparam logic [3:0] C_NDIG = 4'(NDIG);

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [NDIG-1:0]   r_seen, w_seen_nxt, w_seen_set, w_dig_oh;
  logic [4*NDIG-1:0] r_data;
  logic [NDIG-1:0]   r_err;
  logic [TW-1:0]     r_tcnt, w_tcnt_nxt, w_tinc;
  logic              r_timeout, w_timeout_nxt;
  logic [7:0]        r_drop;
  logic [3:0]        w_nib;
  logic              w_bad;
  logic              w_in_range, w_hit, w_accept, w_full;

  assign w_in_range = ({1'b0, dig_i} < C_NDIG);
  assign w_hit      = seg_valid_i && w_in_range;
  assign w_accept   = w_hit && (r_state == COLLECT);
  assign w_dig_oh   = {{(NDIG-1){1'b0}}, 1'b1} << dig_i;
  assign w_seen_set = r_seen | (w_accept ? w_dig_oh : '0);
  assign w_full     = &w_seen_set;
  // Age of the partial frame after this edge: 1 on its first sample, 0 if none.
  assign w_tinc     = (r_seen == '0) ? (w_accept ? TW'(1) : '0) : (r_tcnt + TW'(1));

  // Segment pattern decode; unknown patterns give nibble 0 and flag an error.
  always_comb begin
    w_nib = 4'h0;
    w_bad = 1'b0;
    case (seg_i)
      7'h40: w_nib = 4'h0;
      7'h79: w_nib = 4'h1;
      7'h24: w_nib = 4'h2;
      7'h30: w_nib = 4'h3;
      7'h19: w_nib = 4'h4;
      7'h12: w_nib = 4'h5;
      7'h02: w_nib = 4'h6;
      7'h78: w_nib = 4'h7;
      7'h00: w_nib = 4'h8;
      7'h10: w_nib = 4'h9;
      7'h08: w_nib = 4'hA;
      7'h03: w_nib = 4'hB;
      7'h46: w_nib = 4'hC;
      7'h21: w_nib = 4'hD;
      7'h06: w_nib = 4'hE;
      7'h0E: w_nib = 4'hF;
      default: w_bad = 1'b1;
    endcase
  end

  // Next state, seen set, frame age and timeout pulse; completion beats timeout.
  always_comb begin
    w_state_nxt   = r_state;
    w_seen_nxt    = r_seen;
    w_tcnt_nxt    = r_tcnt;
    w_timeout_nxt = 1'b0;
    case (r_state)
      COLLECT: begin
        if (w_full) begin
          w_state_nxt = HOLD;
          w_seen_nxt  = '0;
          w_tcnt_nxt  = '0;
        end else if ((w_seen_set != '0) && (w_tinc == TW'(TMO))) begin
          w_seen_nxt    = '0;
          w_tcnt_nxt    = '0;
          w_timeout_nxt = 1'b1;
        end else begin
          w_seen_nxt = w_seen_set;
          w_tcnt_nxt = w_tinc;
        end
      end
      HOLD: begin
        if (frame_ready_i) begin
          w_state_nxt = COLLECT;
        end
      end
      default: w_state_nxt = COLLECT;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= COLLECT;
      r_seen    <= '0;
      r_tcnt    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_seen    <= w_seen_nxt;
      r_tcnt    <= w_tcnt_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  // Slot storage; written only while collecting so the held frame stays put.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_data <= '0;
      r_err  <= '0;
    end else begin
      for (int k = 0; k < NDIG; k++) begin
        if (w_accept && w_dig_oh[k]) begin
          r_data[4*k +: 4] <= w_nib;
          r_err[k]         <= w_bad;
        end
      end
    end
  end

  // Saturating count of in-range samples arriving while a frame is held.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_drop <= 8'd0;
    end else if ((r_state == HOLD) && w_hit && (r_drop != 8'hFF)) begin
      r_drop <= r_drop + 8'd1;
    end
  end

  assign frame_valid_o = (r_state == HOLD);
  assign frame_data_o  = r_data;
  assign err_mask_o    = r_err;
  assign timeout_o     = r_timeout;
  assign drop_cnt_o    = r_drop;

endmodule
`default_nettype wire
